// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter.
// Holds FSM state, owner encoding, arbitration modes and the access bundle.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

    localparam logic ARB_RR    = 1'b0;
    localparam logic ARB_FIXED = 1'b1;

    // Everything latched at the granting edge.
    typedef struct packed {
        owner_t      owner;
        logic        we;
        logic        err;
        logic [29:0] idx;
        logic [31:0] wdata;
    } acc_t;

    // Misaligned or beyond the end of memory.
    function automatic logic addr_err(
        input logic [31:0] addr,
        input int unsigned depth
    );
        return (addr[1:0] != 2'b00) ||
               ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/arb2.sv
// Two-requester arbiter, bit 0 = fetch, bit 1 = data.
// Ports: i_req[1:0], i_last_owner, i_mode (0 rr, 1 fixed) -> o_gnt one-hot.
module arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  owner_t     i_last_owner,
    input  logic       i_mode,
    output logic [1:0] o_gnt
);

    logic w_tie_to_d;

    // On a tie, fixed mode always favours data; round-robin
    // hands the port to whoever did not have it last.
    assign w_tie_to_d = (i_mode == ARB_FIXED) ||
                        (i_last_owner == OWN_IF);

    always_comb begin
        o_gnt = 2'b00;
        unique case (1'b1)
            (i_req == 2'b01): o_gnt = 2'b01;
            (i_req == 2'b10): o_gnt = 2'b10;
            (i_req == 2'b11): o_gnt = w_tie_to_d ? 2'b10 : 2'b01;
            default:          o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Ports: i_clk, i_rst_n (sync, active low); fetch i_if_*/o_if_*;
//        data i_d_*/o_d_*; memory o_mem_we/o_mem_a/o_mem_wd, i_mem_rd.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DEPTH       = 128,
    parameter int WAIT_STATES = 0,
    parameter int ARB_MODE    = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,
    output logic        o_if_err,
    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    output logic        o_d_gnt,
    output logic        o_d_rvalid,
    output logic [31:0] o_d_rdata,
    output logic        o_d_err,
    output logic        o_mem_we,
    output logic [31:0] o_mem_a,
    output logic [31:0] o_mem_wd,
    input  logic [31:0] i_mem_rd
);

    localparam logic [3:0] CNT_INIT =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam state_t ST_GNT =
        (WAIT_STATES > 0) ? WAIT : ACCESS;
    localparam logic MODE = (ARB_MODE != 0);

    state_t      r_state;
    state_t      w_next;
    owner_t      r_last_owner;
    acc_t        r_acc;
    acc_t        w_acc;
    logic [3:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_rerr;
    logic        w_arb_ok;
    logic        w_grant;
    logic [1:0]  w_req;
    logic [1:0]  w_gnt;

    // Grants only happen from IDLE or RESP and never during reset.
    assign w_arb_ok = i_rst_n &&
                      ((r_state == IDLE) || (r_state == RESP));
    assign w_req    = {i_d_req, i_if_req} & {2{w_arb_ok}};

    arb2 u_arb2 (
        .i_req        (w_req),
        .i_last_owner (r_last_owner),
        .i_mode       (MODE),
        .o_gnt        (w_gnt)
    );

    assign w_grant  = |w_gnt;
    assign o_if_gnt = w_gnt[0];
    assign o_d_gnt  = w_gnt[1];

    // Bundle for whichever port is granted this cycle.
    always_comb begin
        w_acc = '0;
        if (w_gnt[1]) begin
            w_acc.owner = OWN_D;
            w_acc.we    = i_d_we;
            w_acc.idx   = i_d_addr[31:2];
            w_acc.wdata = i_d_wdata;
            w_acc.err   = addr_err(i_d_addr, DEPTH);
        end else begin
            w_acc.owner = OWN_IF;
            w_acc.we    = 1'b0;
            w_acc.idx   = i_if_addr[31:2];
            w_acc.wdata = '0;
            w_acc.err   = addr_err(i_if_addr, DEPTH);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last_owner <= OWN_D;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_rdata      <= '0;
            r_rerr       <= 1'b0;
        end else begin
            if (w_grant) begin
                r_acc        <= w_acc;
                r_last_owner <= w_acc.owner;
                r_cnt        <= CNT_INIT;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Stores and faults return zero data.
            if (r_state == ACCESS) begin
                r_rdata <= (r_acc.err || r_acc.we) ? '0 : i_mem_rd;
                r_rerr  <= r_acc.err;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_grant ? ST_GNT : IDLE;
            WAIT:    w_next = (r_cnt == 4'd0) ? ACCESS : WAIT;
            ACCESS:  w_next = RESP;
            RESP:    w_next = w_grant ? ST_GNT : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_mem_we    = 1'b0;
        o_mem_a     = '0;
        o_mem_wd    = '0;
        o_if_rvalid = 1'b0;
        o_if_rdata  = '0;
        o_if_err    = 1'b0;
        o_d_rvalid  = 1'b0;
        o_d_rdata   = '0;
        o_d_err     = 1'b0;
        case (r_state)
            WAIT: begin
                o_mem_a = {2'b00, r_acc.idx};
            end
            ACCESS: begin
                o_mem_a  = {2'b00, r_acc.idx};
                o_mem_wd = r_acc.wdata;
                // rst_n gate kills a write caught by reset mid-access.
                o_mem_we = r_acc.we & ~r_acc.err & i_rst_n;
            end
            RESP: begin
                if (r_acc.owner == OWN_D) begin
                    o_d_rvalid = 1'b1;
                    o_d_rdata  = r_rdata;
                    o_d_err    = r_rerr;
                end else begin
                    o_if_rvalid = 1'b1;
                    o_if_rdata  = r_rdata;
                    o_if_err    = r_rerr;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: three instances
// (rr/no wait, rr/3 wait states, fixed priority), each with a memory model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int ND = 3;
    localparam int WS_P [ND] = '{0, 3, 0};
    localparam int AM_P [ND] = '{0, 0, 1};

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   load_req = 1'b1;

    logic        if_req [ND];
    logic [31:0] if_addr [ND];
    logic        d_req [ND];
    logic        d_we [ND];
    logic [31:0] d_addr [ND];
    logic [31:0] d_wdata [ND];
    logic        if_gnt [ND];
    logic        if_rvalid [ND];
    logic [31:0] if_rdata [ND];
    logic        if_err [ND];
    logic        d_gnt [ND];
    logic        d_rvalid [ND];
    logic [31:0] d_rdata [ND];
    logic        d_err [ND];
    logic        mem_we [ND];
    logic [31:0] mem_a [ND];
    logic [31:0] mem_wd [ND];
    logic [31:0] mem_rd [ND];

    logic [31:0] mem [ND][128];
    int          we_cnt [ND] = '{0, 0, 0};
    exp_t        q [ND][$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        mem_port_arbiter #(
            .DEPTH       (128),
            .WAIT_STATES (WS_P[g]),
            .ARB_MODE    (AM_P[g])
        ) dut (
            .i_clk       (clk),
            .i_rst_n     (rst_n),
            .i_if_req    (if_req[g]),
            .i_if_addr   (if_addr[g]),
            .o_if_gnt    (if_gnt[g]),
            .o_if_rvalid (if_rvalid[g]),
            .o_if_rdata  (if_rdata[g]),
            .o_if_err    (if_err[g]),
            .i_d_req     (d_req[g]),
            .i_d_we      (d_we[g]),
            .i_d_addr    (d_addr[g]),
            .i_d_wdata   (d_wdata[g]),
            .o_d_gnt     (d_gnt[g]),
            .o_d_rvalid  (d_rvalid[g]),
            .o_d_rdata   (d_rdata[g]),
            .o_d_err     (d_err[g]),
            .o_mem_we    (mem_we[g]),
            .o_mem_a     (mem_a[g]),
            .o_mem_wd    (mem_wd[g]),
            .i_mem_rd    (mem_rd[g])
        );
    end

    // Memory models: word i of instance g holds 0x10gg00ii unless overridden.
    always_comb begin
        for (int g = 0; g < ND; g++) begin
            mem_rd[g] = (mem_a[g] < 128) ? mem[g][mem_a[g][6:0]] : 32'hBADC0DE5;
        end
    end

    always @(posedge clk) begin
        for (int g = 0; g < ND; g++) begin
            if (load_req) begin
                for (int i = 0; i < 128; i++) begin
                    mem[g][i] <= 32'h1000_0000 | 32'(g << 16) | 32'(i);
                end
                if (g == 0) begin
                    mem[0][3] <= 32'hDEADBEEF;
                    mem[0][8] <= 32'h88888888;
                end
            end else if (mem_we[g]) begin
                we_cnt[g] <= we_cnt[g] + 1;
                if (mem_a[g] < 128) mem[g][mem_a[g][6:0]] <= mem_wd[g];
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, expv);
        end
    endtask

    // Response monitor: pops one expectation per rvalid.
    always @(negedge clk) begin
        for (int g = 0; g < ND; g++) begin
            if (if_rvalid[g] || d_rvalid[g]) begin
                exp_t e;
                if (q[g].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL dut%0d unexpected rvalid at cyc %0d", g, cyc);
                end else begin
                    e = q[g].pop_front();
                    chk($sformatf("dut%0d rvalid port", g),
                        32'({if_rvalid[g], d_rvalid[g]}),
                        e.is_d ? 32'd1 : 32'd2);
                    chk($sformatf("dut%0d rdata", g),
                        e.is_d ? d_rdata[g] : if_rdata[g], e.rdata);
                    chk($sformatf("dut%0d err", g),
                        32'(e.is_d ? d_err[g] : if_err[g]), 32'(e.err));
                    chk($sformatf("dut%0d latency", g), cyc, e.cyc);
                end
            end
        end
    end

    task automatic issue(int d, bit is_d, bit we, logic [31:0] addr,
                         logic [31:0] wd, logic [31:0] xr, logic xe,
                         output int waited);
        int n = 0;
        @(negedge clk);
        if (is_d) begin
            d_req[d] = 1'b1;
            d_we[d] = we;
            d_addr[d] = addr;
            d_wdata[d] = wd;
        end else begin
            if_req[d] = 1'b1;
            if_addr[d] = addr;
        end
        #1;
        while (!(is_d ? d_gnt[d] : if_gnt[d]) && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        waited = n;
        if (n >= 40) begin
            total++;
            bad++;
            $display("FAIL dut%0d gnt timeout", d);
        end else begin
            q[d].push_back('{is_d: is_d, rdata: xr, err: xe,
                             cyc: cyc + 2 + WS_P[d]});
        end
        @(posedge clk);
        #1;
        if (is_d) begin
            d_req[d] = 1'b0;
            d_we[d] = 1'b0;
        end else begin
            if_req[d] = 1'b0;
        end
    endtask

    task automatic wait_gnt(int d, output logic [1:0] gv);
        int n = 0;
        while (!(if_gnt[d] || d_gnt[d]) && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        gv = {if_gnt[d], d_gnt[d]};
    endtask

    task automatic drain(int d);
        int n = 0;
        while (q[d].size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL dut%0d drain timeout, %0d left", d, q[d].size());
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int c0;
        int lastc;
        logic [1:0] gv;
        bit want_d;

        for (int g = 0; g < ND; g++) begin
            if_req[g] = 1'b0;
            if_addr[g] = '0;
            d_req[g] = 1'b0;
            d_we[g] = 1'b0;
            d_addr[g] = '0;
            d_wdata[g] = '0;
        end
        repeat (3) @(negedge clk);
        load_req = 1'b0;

        // Reset state, including a request held during reset.
        if_req[0] = 1'b1;
        #1;
        chk("rst if_gnt gated", 32'(if_gnt[0]), 32'd0);
        if_req[0] = 1'b0;
        for (int g = 0; g < ND; g++) begin
            chk($sformatf("rst dut%0d rvalid", g),
                32'({if_rvalid[g], d_rvalid[g]}), 32'd0);
            chk($sformatf("rst dut%0d mem_we", g), 32'(mem_we[g]), 32'd0);
            chk($sformatf("rst dut%0d mem_a", g), mem_a[g], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Plain fetch of word 3.
        issue(0, 0, 0, 32'h0C, 0, 32'hDEADBEEF, 0, w);
        chk("fetch gnt same cycle", w, 0);
        chk("fetch mem_a", mem_a[0], 32'd3);
        chk("fetch mem_we", 32'(mem_we[0]), 32'd0);
        drain(0);

        // Store then load of word 4.
        issue(0, 1, 1, 32'h10, 32'h12345678, 32'h0, 0, w);
        chk("store mem_we", 32'(mem_we[0]), 32'd1);
        chk("store mem_a", mem_a[0], 32'd4);
        chk("store mem_wd", mem_wd[0], 32'h12345678);
        @(posedge clk);
        #1;
        chk("store we one cycle", 32'(mem_we[0]), 32'd0);
        chk("resp idle mem_a", mem_a[0], 32'd0);
        drain(0);
        chk("store landed", mem[0][4], 32'h12345678);
        issue(0, 1, 0, 32'h10, 0, 32'h12345678, 0, w);
        drain(0);

        // Misaligned store must not write.
        c0 = we_cnt[0];
        issue(0, 1, 1, 32'h12, 32'hCAFEF00D, 32'h0, 1, w);
        chk("bad store mem_we", 32'(mem_we[0]), 32'd0);
        drain(0);
        chk("bad store no write", we_cnt[0], c0);
        chk("bad store mem kept", mem[0][4], 32'h12345678);

        // Fetch beyond DEPTH.
        issue(0, 0, 0, 32'h200, 0, 32'h0, 1, w);
        chk("oob mem_a", mem_a[0], 32'd128);
        drain(0);

        // Round-robin with both held, from reset: IF, D, IF, ...
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        if_req[0] = 1'b1;
        if_addr[0] = 32'h0C;
        d_req[0] = 1'b1;
        d_we[0] = 1'b0;
        d_addr[0] = 32'h10;
        #1;
        lastc = 0;
        for (int k = 0; k < 6; k++) begin
            wait_gnt(0, gv);
            want_d = (k % 2) == 1;
            chk($sformatf("rr grant %0d", k), 32'(gv),
                want_d ? 32'd1 : 32'd2);
            if (k > 0) chk($sformatf("rr spacing %0d", k), cyc - lastc, 2);
            lastc = cyc;
            q[0].push_back('{is_d: want_d,
                             rdata: want_d ? 32'h12345678 : 32'hDEADBEEF,
                             err: 1'b0, cyc: cyc + 2});
            if (k < 5) begin
                @(negedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        if_req[0] = 1'b0;
        d_req[0] = 1'b0;
        drain(0);

        // Reset lands on the ACCESS cycle of a store to word 8.
        issue(0, 1, 1, 32'h20, 32'hBAD0BAD0, 32'h0, 0, w);
        rst_n = 1'b0;
        q[0].delete();
        #1;
        chk("reset kills mem_we", 32'(mem_we[0]), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset word 8 kept", mem[0][8], 32'h88888888);
        chk("reset idle mem_a", mem_a[0], 32'd0);
        repeat (4) @(negedge clk);
        if_req[0] = 1'b1;
        if_addr[0] = 32'h0C;
        d_req[0] = 1'b1;
        d_addr[0] = 32'h10;
        #1;
        chk("post reset tie", 32'({if_gnt[0], d_gnt[0]}), 32'd2);
        q[0].push_back('{is_d: 1'b0, rdata: 32'hDEADBEEF, err: 1'b0,
                         cyc: cyc + 2});
        @(posedge clk);
        #1;
        if_req[0] = 1'b0;
        d_req[0] = 1'b0;
        drain(0);

        // Three wait states.
        c0 = we_cnt[1];
        issue(1, 0, 0, 32'h14, 0, 32'h10010005, 0, w);
        chk("ws mem_a in wait", mem_a[1], 32'd5);
        chk("ws mem_we in wait", 32'(mem_we[1]), 32'd0);
        drain(1);
        chk("ws no writes", we_cnt[1], c0);

        // Fixed priority: data wins until it lets go.
        @(negedge clk);
        if_req[2] = 1'b1;
        if_addr[2] = 32'h0C;
        d_req[2] = 1'b1;
        d_we[2] = 1'b0;
        d_addr[2] = 32'h18;
        #1;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(2, gv);
            chk($sformatf("fixed grant %0d", k), 32'(gv), 32'd1);
            q[2].push_back('{is_d: 1'b1, rdata: 32'h10020006, err: 1'b0,
                             cyc: cyc + 2});
            if (k < 3) begin
                @(negedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        d_req[2] = 1'b0;
        wait_gnt(2, gv);
        chk("fixed then fetch", 32'(gv), 32'd2);
        q[2].push_back('{is_d: 1'b0, rdata: 32'h10020003, err: 1'b0,
                         cyc: cyc + 2});
        @(posedge clk);
        #1;
        if_req[2] = 1'b0;
        drain(2);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
